// File: rtl/load_hazard_ctrl_if.sv
// Decode/execute-side signals seen by the load-use hazard unit, plus its stall controls and statistics.
interface load_hazard_ctrl_if #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned REG_AW  = 3,
  parameter int unsigned CNT_W   = 16
);
  logic [INSTR_W-1:0] fd_instr;
  logic               fd_valid;
  logic               fd_rs_used;
  logic               fd_rt_used;
  logic [REG_AW-1:0]  dx_rd;
  logic               dx_mem_read;
  logic               dx_valid;
  logic               flush;
  logic               mem_stall;
  logic               clr_stats;
  logic               pc_write;
  logic               if_write;
  logic               enable_nop;
  logic [CNT_W-1:0]   stall_cycles;
  logic [CNT_W-1:0]   stall_events;

  // Pipeline side: drives decode/execute state, consumes stall controls.
  modport master (
    output fd_instr, fd_valid, fd_rs_used, fd_rt_used,
    output dx_rd, dx_mem_read, dx_valid, flush, mem_stall, clr_stats,
    input  pc_write, if_write, enable_nop, stall_cycles, stall_events
  );

  // Hazard unit side.
  modport slave (
    input  fd_instr, fd_valid, fd_rs_used, fd_rt_used,
    input  dx_rd, dx_mem_read, dx_valid, flush, mem_stall, clr_stats,
    output pc_write, if_write, enable_nop, stall_cycles, stall_events
  );
endinterface

// File: rtl/load_hazard_ctrl.sv
// Load-use hazard unit: compares decode sources against the load in DX and loads still
// in flight for LOAD_LAT-1 further cycles, and keeps saturating stall statistics.
module load_hazard_ctrl #(
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned RS_HI    = 10,
  parameter int unsigned RT_HI    = 7,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic clk,
  input  logic rst,
  load_hazard_ctrl_if.slave bus
);

  localparam int unsigned RS_LO = RS_HI - REG_AW + 1;
  localparam int unsigned RT_LO = RT_HI - REG_AW + 1;
  // At least one slot so the compare loop stays well-formed; tied off when LOAD_LAT=1.
  localparam int unsigned TRK_D = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic              dx_load;
  logic              rs_match;
  logic              rt_match;
  logic              hazard;
  logic [TRK_D-1:0]  trk_vld;
  logic [REG_AW-1:0] trk_rd [TRK_D];
  logic [CNT_W-1:0]  cycles_q;
  logic [CNT_W-1:0]  events_q;
  logic              prev_nop_q;
  logic              unused_instr_bits;

  assign rs      = bus.fd_instr[RS_HI:RS_LO];
  assign rt      = bus.fd_instr[RT_HI:RT_LO];
  assign dx_load = bus.dx_mem_read & bus.dx_valid;
  // Opcode/immediate bits are irrelevant to hazard detection.
  assign unused_instr_bits = ^bus.fd_instr;

  generate
    if (LOAD_LAT > 1) begin : g_trk
      // Age loads that have left DX; the whole tracker freezes with the pipeline.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          trk_vld <= '0;
          for (int k = 0; k < int'(TRK_D); k++) trk_rd[k] <= '0;
        end else if (!bus.mem_stall) begin
          for (int k = int'(TRK_D) - 1; k > 0; k--) begin
            trk_vld[k] <= trk_vld[k-1];
            trk_rd[k]  <= trk_rd[k-1];
          end
          trk_vld[0] <= dx_load;
          trk_rd[0]  <= bus.dx_rd;
        end
      end
    end else begin : g_no_trk
      // Classic single-cycle latency: nothing in flight beyond DX.
      always_comb begin
        trk_vld = '0;
        for (int k = 0; k < int'(TRK_D); k++) trk_rd[k] = '0;
      end
    end
  endgenerate

  // Source-register matches against DX load and every tracked load.
  always_comb begin
    rs_match = dx_load && (bus.dx_rd == rs);
    rt_match = dx_load && (bus.dx_rd == rt);
    for (int k = 0; k < int'(TRK_D); k++) begin
      rs_match = rs_match || (trk_vld[k] && (trk_rd[k] == rs));
      rt_match = rt_match || (trk_vld[k] && (trk_rd[k] == rt));
    end
  end

  // A killed decode instruction never stalls.
  assign hazard = bus.fd_valid && !bus.flush &&
                  ((bus.fd_rs_used && rs_match) || (bus.fd_rt_used && rt_match));

  // Stall controls: memory freeze beats hazard bubble beats normal flow.
  always_comb begin
    bus.pc_write   = 1'b1;
    bus.if_write   = 1'b1;
    bus.enable_nop = 1'b0;
    if (bus.mem_stall) begin
      bus.pc_write = 1'b0;
      bus.if_write = 1'b0;
    end else if (hazard) begin
      bus.pc_write   = 1'b0;
      bus.if_write   = 1'b0;
      bus.enable_nop = 1'b1;
    end
  end

  // Saturating stall statistics; frozen cycles leave the episode flag untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_q   <= '0;
      events_q   <= '0;
      prev_nop_q <= 1'b0;
    end else begin
      if (bus.clr_stats) begin
        cycles_q <= '0;
        events_q <= '0;
      end else begin
        if (bus.enable_nop && (cycles_q != CNT_MAX)) cycles_q <= cycles_q + CNT_W'(1);
        if (bus.enable_nop && !prev_nop_q && (events_q != CNT_MAX))
          events_q <= events_q + CNT_W'(1);
      end
      if (!bus.mem_stall) prev_nop_q <= bus.enable_nop;
    end
  end

  assign bus.stall_cycles = cycles_q;
  assign bus.stall_events = events_q;

endmodule

// File: tb/tb_load_hazard_ctrl.sv
// Drives a LOAD_LAT=1 / CNT_W=16 unit and a LOAD_LAT=3 / CNT_W=4 unit from shared stimulus,
// comparing both against a behavioural model through a scoreboard queue.
module tb_load_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fd_instr;
  logic        fd_valid, fd_rs_used, fd_rt_used;
  logic [2:0]  dx_rd;
  logic        dx_mem_read, dx_valid, flush, mem_stall, clr_stats;

  always #5 clk = ~clk;

  load_hazard_ctrl_if #(.CNT_W(16)) if1 ();
  load_hazard_ctrl_if #(.CNT_W(4))  if3 ();

  assign if1.fd_instr = fd_instr;       assign if3.fd_instr = fd_instr;
  assign if1.fd_valid = fd_valid;       assign if3.fd_valid = fd_valid;
  assign if1.fd_rs_used = fd_rs_used;   assign if3.fd_rs_used = fd_rs_used;
  assign if1.fd_rt_used = fd_rt_used;   assign if3.fd_rt_used = fd_rt_used;
  assign if1.dx_rd = dx_rd;             assign if3.dx_rd = dx_rd;
  assign if1.dx_mem_read = dx_mem_read; assign if3.dx_mem_read = dx_mem_read;
  assign if1.dx_valid = dx_valid;       assign if3.dx_valid = dx_valid;
  assign if1.flush = flush;             assign if3.flush = flush;
  assign if1.mem_stall = mem_stall;     assign if3.mem_stall = mem_stall;
  assign if1.clr_stats = clr_stats;     assign if3.clr_stats = clr_stats;

  load_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u_lat1 (.clk(clk), .rst(rst), .bus(if1));
  load_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(4))  u_lat3 (.clk(clk), .rst(rst), .bus(if3));

  typedef struct {
    logic        p1, i1, n1;
    logic [15:0] c1, e1;
    logic        p3, i3, n3;
    logic [3:0]  c3, e3;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: loads seen leaving DX in the last two live cycles, counters, episode flags.
  logic        h_v [2];
  logic [2:0]  h_rd [2];
  logic [15:0] c1, e1;
  logic [3:0]  c3, e3;
  logic        pv1, pv3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic hit(input logic [2:0] r, input bit deep);
    logic h;
    h = dx_mem_read && dx_valid && (dx_rd == r);
    if (deep) begin
      for (int k = 0; k < 2; k++) if (h_v[k] && (h_rd[k] == r)) h = 1'b1;
    end
    return h;
  endfunction

  function automatic logic hz(input bit deep);
    logic [2:0] rs, rt;
    rs = fd_instr[10:8];
    rt = fd_instr[7:5];
    return fd_valid && !flush && ((fd_rs_used && hit(rs, deep)) || (fd_rt_used && hit(rt, deep)));
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.n1 = !mem_stall && hz(1'b0);
    e.p1 = !mem_stall && !hz(1'b0);
    e.i1 = e.p1;
    e.n3 = !mem_stall && hz(1'b1);
    e.p3 = !mem_stall && !hz(1'b1);
    e.i3 = e.p3;
    e.c1 = c1; e.e1 = e1; e.c3 = c3; e.e3 = e3;
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin h_v[k] = 1'b0; h_rd[k] = 3'd0; end
    c1 = '0; e1 = '0; c3 = '0; e3 = '0; pv1 = 1'b0; pv3 = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs applied during that cycle.
  task automatic model_update();
    exp_t e;
    e = predict();
    if (clr_stats) begin
      c1 = '0; e1 = '0; c3 = '0; e3 = '0;
    end else begin
      if (e.n1 && c1 != 16'hffff) c1 = c1 + 16'd1;
      if (e.n1 && !pv1 && e1 != 16'hffff) e1 = e1 + 16'd1;
      if (e.n3 && c3 != 4'hf) c3 = c3 + 4'd1;
      if (e.n3 && !pv3 && e3 != 4'hf) e3 = e3 + 4'd1;
    end
    if (!mem_stall) begin
      pv1 = e.n1;
      pv3 = e.n3;
      h_v[1] = h_v[0]; h_rd[1] = h_rd[0];
      h_v[0] = dx_mem_read && dx_valid; h_rd[0] = dx_rd;
    end
  endtask

  task automatic set_in(input logic [2:0] rs, input logic [2:0] rt, input logic fv,
                        input logic ru, input logic tu, input logic [2:0] drd,
                        input logic dld, input logic dv, input logic fl = 1'b0,
                        input logic ms = 1'b0, input logic clr = 1'b0);
    fd_instr    = {5'b10001, rs, rt, 5'b00000};
    fd_valid    = fv;
    fd_rs_used  = ru;
    fd_rt_used  = tu;
    dx_rd       = drd;
    dx_mem_read = dld;
    dx_valid    = dv;
    flush       = fl;
    mem_stall   = ms;
    clr_stats   = clr;
  endtask

  // Called just after a rising edge with inputs applied: queue expectation, check mid-cycle, clock.
  task automatic step();
    exp_t e;
    sb.push_back(predict());
    @(negedge clk);
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq("l1_pc_write",   32'(if1.pc_write),     32'(e.p1));
      check_eq("l1_if_write",   32'(if1.if_write),     32'(e.i1));
      check_eq("l1_enable_nop", 32'(if1.enable_nop),   32'(e.n1));
      check_eq("l1_cycles",     32'(if1.stall_cycles), 32'(e.c1));
      check_eq("l1_events",     32'(if1.stall_events), 32'(e.e1));
      check_eq("l3_pc_write",   32'(if3.pc_write),     32'(e.p3));
      check_eq("l3_if_write",   32'(if3.if_write),     32'(e.i3));
      check_eq("l3_enable_nop", 32'(if3.enable_nop),   32'(e.n3));
      check_eq("l3_cycles",     32'(if3.stall_cycles), 32'(e.c3));
      check_eq("l3_events",     32'(if3.stall_events), 32'(e.e3));
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    check_eq("rst_pc_write", 32'(if3.pc_write), 32'd1);
    check_eq("rst_if_write", 32'(if3.if_write), 32'd1);
    check_eq("rst_nop",      32'(if3.enable_nop), 32'd0);
    check_eq("rst_cycles",   32'(if1.stall_cycles), 32'd0);
    check_eq("rst_events",   32'(if3.stall_events), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    model_update();
    #1;

    // Load r3 in DX, dependent add r1,r3,r2 in decode, then bubbles behind it.
    set_in(3, 2, 1, 1, 0, 3, 1, 1); step();
    set_in(3, 2, 1, 1, 0, 0, 0, 0); step();
    step();
    step();
    check_eq("t1_l1_cycles", 32'(if1.stall_cycles), 32'd1);
    check_eq("t1_l1_events", 32'(if1.stall_events), 32'd1);
    check_eq("t2_l3_cycles", 32'(if3.stall_cycles), 32'd3);
    check_eq("t2_l3_events", 32'(if3.stall_events), 32'd1);

    // Independent use of r6 after load of r5.
    set_in(6, 0, 1, 1, 0, 5, 1, 1); step();
    set_in(6, 0, 1, 1, 0, 0, 0, 0); step();
    step();

    // Flush kills the hazard; unused Rt matching does not stall.
    set_in(4, 0, 1, 1, 0, 4, 1, 1, 1'b1); step();
    set_in(1, 4, 1, 1, 0, 4, 1, 1);       step();

    // Rs and Rt both matching: one episode only.
    set_in(2, 2, 1, 1, 1, 2, 1, 1); step();
    set_in(2, 2, 1, 1, 1, 0, 0, 0); step();
    step();
    step();

    // Memory freeze for 4 cycles in the middle of a 3-cycle stall.
    set_in(5, 0, 1, 1, 0, 5, 1, 1); step();
    set_in(5, 0, 1, 1, 0, 0, 0, 0, 1'b0, 1'b1);
    repeat (4) step();
    set_in(5, 0, 1, 1, 0, 0, 0, 0); step();
    step();
    step();
    check_eq("t4_l3_cycles", 32'(if3.stall_cycles), 32'd9);
    check_eq("t4_l3_events", 32'(if3.stall_events), 32'd3);
    check_eq("t4_l1_cycles", 32'(if1.stall_cycles), 32'd3);

    // 20 back-to-back stall cycles saturate the 4-bit counter, then clear.
    set_in(7, 0, 1, 1, 0, 7, 1, 1);
    repeat (20) step();
    check_eq("t5_l3_sat", 32'(if3.stall_cycles), 32'd15);
    check_eq("t5_l1_cnt", 32'(if1.stall_cycles), 32'd23);
    set_in(7, 0, 1, 1, 0, 7, 1, 1, 1'b0, 1'b0, 1'b1); step();
    check_eq("t5_l3_clr", 32'(if3.stall_cycles), 32'd0);
    check_eq("t5_l1_clr", 32'(if1.stall_events), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();

    // Asynchronous reset while a tracked load is still stalling decode.
    set_in(3, 0, 1, 1, 0, 3, 1, 1); step();
    set_in(3, 0, 1, 1, 0, 0, 0, 0);
    #2;
    check_eq("t6_pre_nop", 32'(if3.enable_nop), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t6_pc_write", 32'(if3.pc_write), 32'd1);
    check_eq("t6_nop",      32'(if3.enable_nop), 32'd0);
    check_eq("t6_cycles",   32'(if3.stall_cycles), 32'd0);
    check_eq("t6_events",   32'(if3.stall_events), 32'd0);
    check_eq("t6_l1_cyc",   32'(if1.stall_cycles), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    model_update();
    #1;
    set_in(3, 0, 1, 1, 0, 0, 0, 0); step();
    set_in(3, 0, 1, 1, 0, 3, 1, 1); step();

    // Mixed traffic with a small register pool to provoke frequent matches.
    repeat (80) begin
      set_in(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 1'($urandom_range(0, 7) != 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 15) == 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
